// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   cpu_req, cpu_we       CPU access request, 1 = store / 0 = load (held while stall=1)
//   cpu_addr, cpu_wdata   CPU byte address and right-aligned store data
//   cpu_addr_mode         [1:0] 00 byte, 01 half, 1x word; [2] unsigned load
//   cpu_rdata             load result (0 unless a load hit is being returned)
//   stall                 CPU must hold its request
//   mem_req, mem_we       memory request / write strobe, held until mem_ready
//   mem_addr, mem_wdata   memory address and write data
//   mem_addr_mode         memory access mode
//   mem_rdata, mem_ready  memory read word, one-cycle completion pulse
module dcache_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [2:0]            cpu_addr_mode,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_addr_mode,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int IDX   = $clog2(SETS);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;
   state_t state;

   logic [SETS-1:0]       valid;
   logic [TAG_W-1:0]      tag_mem  [SETS];
   logic [DATA_WIDTH-1:0] data_mem [SETS];

   logic [IDX-1:0]        idx;
   logic [TAG_W-1:0]      tag;
   logic [1:0]            off;
   logic                  hit;
   logic [DATA_WIDTH-1:0] line;

   assign idx  = cpu_addr[IDX+1:2];
   assign tag  = cpu_addr[DATA_WIDTH-1:IDX+2];
   assign off  = cpu_addr[1:0];
   assign line = data_mem[idx];
   assign hit  = valid[idx] && (tag_mem[idx] == tag);

   // Load extraction; misaligned halves fall back to the half selected by off[1]
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_val;

   always_comb begin
      ld_byte = line[{off, 3'b000} +: 8];
      ld_half = line[{off[1], 4'b0000} +: 16];
      case (cpu_addr_mode[1:0])
         2'b00:   ld_val = cpu_addr_mode[2] ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                            : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         2'b01:   ld_val = cpu_addr_mode[2] ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                            : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         default: ld_val = line;
      endcase
   end

   // Store merge into a resident line: replicate the store data across lanes
   // and keep only the addressed byte(s)
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] st_lanes;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      case (cpu_addr_mode[1:0])
         2'b00: begin
            be       = 4'b0001 << off;
            st_lanes = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            be       = off[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{cpu_wdata[15:0]}};
         end
         default: begin
            be       = 4'b1111;
            st_lanes = cpu_wdata;
         end
      endcase
      merged = line;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[8*b +: 8] = st_lanes[8*b +: 8];
      end
   end

   // CPU-side handshake is combinational so hits add no latency and misses
   // stall in the cycle they are presented
   always_comb begin
      stall     = 1'b0;
      cpu_rdata = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (!cpu_we && hit) cpu_rdata = ld_val;
                  else                stall     = 1'b1;
               end
            end
            FILL, WRITE: stall = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         valid         <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_addr_mode <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req && cpu_we) begin
                  state         <= WRITE;
                  mem_req       <= 1'b1;
                  mem_we        <= 1'b1;
                  mem_addr      <= cpu_addr;
                  mem_wdata     <= cpu_wdata;
                  mem_addr_mode <= cpu_addr_mode;
               end else if (cpu_req && !hit) begin
                  state         <= FILL;
                  mem_req       <= 1'b1;
                  mem_we        <= 1'b0;
                  mem_addr      <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata     <= '0;
                  mem_addr_mode <= 3'b010;
               end
            end
            FILL: begin
               if (mem_ready) begin
                  valid[idx]    <= 1'b1;
                  state         <= IDLE;
                  mem_req       <= 1'b0;
                  mem_addr      <= '0;
                  mem_addr_mode <= 3'b000;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  state         <= RESP;
                  mem_req       <= 1'b0;
                  mem_we        <= 1'b0;
                  mem_addr      <= '0;
                  mem_wdata     <= '0;
                  mem_addr_mode <= 3'b000;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid bits alone guard them. A reset
   // forces state to IDLE asynchronously, so an aborted access writes nothing.
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ready) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= mem_rdata;
      end else if (state == WRITE && mem_ready && hit) begin
         data_mem[idx] <= merged;
      end
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data-cache controller between the CPU load/store stage and the byte-addressed data memory.
- Serves load hits from an internal word array in the same cycle.
- Sequences word-sized line fills on load misses and forwards every store to memory.
- Holds the CPU with stall while memory is busy.

Parameters:
- DATA_WIDTH, 32, data/address width.
- SETS, 16, number of one-word lines (power of 2); index = addr[IDX+1:2], tag = addr[31:IDX+2], IDX = log2(SETS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  access request; held stable while stall=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_addr_mode  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 treated as word; [2]: unsigned load.
- cpu_rdata  out  32  load result, extended per mode.
- stall  out  1  CPU must hold the request.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_addr_mode  out  3  memory access mode.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  one-cycle pulse: access complete, mem_rdata valid.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; all valid bits 0.
  - stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_addr_mode=0, cpu_rdata=0.
  - Tag/data arrays not cleared.
  - Reset mid-FILL/WRITE aborts: mem_req drops immediately; no line is written.
- Alignment: half accesses require addr[0]=0 and word accesses addr[1:0]=0. Misaligned accesses use addr aligned down to the access size; memory is not informed.
- Load extraction from line word W, offset o=addr[1:0]:
  - byte = W[8o+7:8o]; half = W[16·o[1]+15:16·o[1]].
  - Sign-extend if mode[2]=0, zero-extend if 1.
  - cpu_rdata is 0 when no load hit is being returned.
- States:
  - IDLE:
    - No cpu_req: stall=0.
    - Load hit (valid & tag match): cpu_rdata combinational, stall=0, zero added latency.
    - Load miss: stall=1 in the same cycle → FILL.
    - Store: stall=1 → WRITE.
  - FILL:
    - stall=1; mem_req=1, mem_we=0, mem_addr={cpu_addr[31:2],2'b00}, mem_addr_mode=3'b010.
    - On mem_ready: line[idx] ← mem_rdata, tag written, valid=1 → IDLE.
    - The next cycle is a hit and returns data.
    - Miss latency = memory latency + 1 cycle.
  - WRITE:
    - stall=1; mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_addr_mode=cpu_addr_mode.
    - On mem_ready: if the line hits, merge only the addressed byte(s) into it; on a miss the cache is unchanged (no allocate) → RESP.
  - RESP:
    - One cycle, stall=0, mem_req=0, so the CPU retires the store → IDLE.
    - A request presented during RESP is the retiring store, not a new access.
- Timing rules:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_addr_mode are held constant from request until mem_ready.
  - They are driven only in FILL/WRITE and are 0 otherwise.
  - mem_ready outside FILL/WRITE is ignored.
  - mem_ready in the cycle mem_req first rises is accepted (zero-wait memory).
- Conflict misses: a fill overwrites the resident line unconditionally; write-through means no victim writeback.
- Index wrap: addresses differing only in tag map to the same line and evict each other.

Test Plan:
- Reset, then lw 0x00010000 → stall=1, mem_req with mode 010 at 0x00010000. Memory returns 0xDEADBEEF after 3 cycles → next cycle cpu_rdata=0xDEADBEEF, stall=0. A repeat lw gives no mem_req and the same data.
- After the fill above:
  - lb 0x00010003 → 0xFFFFFFDE.
  - lbu 0x00010003 → 0x000000DE.
  - lh 0x00010000 → 0xFFFFBEEF.
  - lhu 0x00010002 → 0x0000DEAD.
  - All are hits with no stall.
- sb 0x00010001 data 0x55 on a hit line → mem_we=1, mode 000 until mem_ready, one RESP cycle with stall=0. A following lw returns 0xDEAD55EF without mem_req.
- sw to an uncached address 0x00010100 → memory write issued. A subsequent lw to 0x00010100 misses and fills (no-write-allocate).
- lw 0x00010000 then lw 0x00010040 (same index, SETS=16) → the second fill evicts the first; a third lw to 0x00010000 misses again.
- Assert rst during FILL two cycles before mem_ready → mem_req=0 immediately, all lines invalid. A later lw to the same address misses.
